// File: rtl/hsv_core_issue_token.sv
// In-order issue stage: a scoreboard of pending destination registers, token
// stamping, a cap on outstanding instructions and a flush/clear sequence.
// Optional macro ISSUE_TOKEN_BYPASS_EN lets this cycle's commit_mask take part in the hazard check.
module hsv_core_issue_token (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        flush_req,
  output logic        flush_ack,
  input  logic        insn_valid_i,
  output logic        insn_ready_o,
  input  logic [31:0] insn_rs_mask,
  input  logic [31:0] insn_rd_mask,
  output logic        issue_valid_o,
  input  logic        issue_ready_i,
  output logic [7:0]  issue_token_o,
  output logic [31:0] issue_rd_mask_o,
  input  logic [31:0] commit_mask,
  input  logic        commit_i
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  state_e      state_q, state_d, state_cur;
  logic        flush_ack_q, flush_ack_d;
  logic        issue_valid_q, issue_valid_d;
  logic [7:0]  issue_token_q, issue_token_d;
  logic [31:0] issue_rd_q, issue_rd_d;
  logic [7:0]  token_q, token_d;
  logic [31:0] pending_q, pending_d;
  logic [7:0]  outstanding_q, outstanding_d;

  logic [31:0] hazard_src;
  logic        hazard;
  logic        accept;
  logic        in_clear;

  // The register holds only RUN/FLUSH. CLEAR is the single FLUSH cycle in which
  // flush_req has already dropped, so it coincides with flush_ack & !flush_req.
  always_comb begin
    state_cur = state_q;
    if (state_q == ST_FLUSH && !flush_req) begin
      state_cur = ST_CLEAR;
    end
    in_clear = (state_cur == ST_CLEAR);

    state_d = state_q;
    case (state_cur)
      ST_RUN:   state_d = flush_req ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = ST_FLUSH;
      ST_CLEAR: state_d = ST_RUN;
      default:  state_d = ST_FLUSH;
    endcase
  end

  always_comb begin
`ifdef ISSUE_TOKEN_BYPASS_EN
    hazard_src = pending_q & ~commit_mask;
`else
    hazard_src = pending_q;
`endif
    hazard = |((insn_rs_mask | insn_rd_mask) & hazard_src & ~32'h1);

    insn_ready_o = !flush_req && !flush_ack_q && !hazard &&
                   (outstanding_q != 8'hFF) &&
                   (!issue_valid_q || issue_ready_i);
    accept = insn_valid_i && insn_ready_o;
  end

  always_comb begin
    flush_ack_d   = flush_req;
    token_d       = token_q;
    pending_d     = pending_q;
    outstanding_d = outstanding_q;

    if (in_clear) begin
      token_d       = 8'd0;
      pending_d     = 32'd0;
      outstanding_d = 8'd0;
    end else begin
      // A bit both retired and re-claimed this cycle ends up set.
      pending_d = (pending_q & ~commit_mask) |
                  (accept ? (insn_rd_mask & ~32'h1) : 32'd0);
      pending_d[0] = 1'b0;
      token_d = token_q + {7'd0, accept};
      if (accept && !commit_i) begin
        outstanding_d = outstanding_q + 8'd1;
      end else if (!accept && commit_i && outstanding_q != 8'd0) begin
        outstanding_d = outstanding_q - 8'd1;
      end
    end
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_token_d = issue_token_q;
    issue_rd_d    = issue_rd_q;

    if (flush_req) begin
      issue_valid_d = 1'b0;
    end else if (accept) begin
      issue_valid_d = 1'b1;
      issue_token_d = token_q;
      issue_rd_d    = insn_rd_mask;
    end else if (issue_ready_i) begin
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q       <= ST_FLUSH;
      flush_ack_q   <= 1'b1;
      issue_valid_q <= 1'b0;
      issue_token_q <= 8'd0;
      issue_rd_q    <= 32'd0;
      token_q       <= 8'd0;
      pending_q     <= 32'd0;
      outstanding_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      flush_ack_q   <= flush_ack_d;
      issue_valid_q <= issue_valid_d;
      issue_token_q <= issue_token_d;
      issue_rd_q    <= issue_rd_d;
      token_q       <= token_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign flush_ack       = flush_ack_q;
  assign issue_valid_o   = issue_valid_q;
  assign issue_token_o   = issue_token_q;
  assign issue_rd_mask_o = issue_rd_q;

endmodule

// File: doc/hsv_core_issue_token.md
HSV_CORE_ISSUE_TOKEN -- requirements
Module: hsv_core_issue_token

Interface
REQ-001 SHALL have ports clk_core (in, 1, core clock) and rst_core_n (in, 1, reset); one clock, reset asynchronous and active-low.
REQ-002 SHALL have port flush_req (in, 1): flush request from control.
REQ-003 SHALL have port flush_ack (out, 1): flush acknowledge.
REQ-004 SHALL have port insn_valid_i (in, 1): decoded instruction valid.
REQ-005 SHALL have port insn_ready_o (out, 1): instruction accepted this cycle when high with insn_valid_i.
REQ-006 SHALL have ports insn_rs_mask (in, reg_mask, 32): source-register one-hot bits; and insn_rd_mask (in, reg_mask, 32): destination-register one-hot bits.
REQ-007 SHALL have port issue_valid_o (out, 1): output stage holds an issued instruction.
REQ-008 SHALL have port issue_ready_i (in, 1): execution units accept the output stage.
REQ-009 SHALL have port issue_token_o (out, insn_token, 8): token assigned to the held instruction.
REQ-010 SHALL have port issue_rd_mask_o (out, reg_mask, 32): rd mask of the held instruction.
REQ-011 SHALL have port commit_mask (in, reg_mask, 32): registers retired this cycle.
REQ-012 SHALL have port commit_i (in, 1): one instruction committed this cycle (ctrl_commit).

Function
REQ-013 SHALL keep a 32-bit pending mask; bit 0 (x0) is always forced 0.
REQ-014 SHALL define hazard = ((insn_rs_mask | insn_rd_mask) & pending & ~32'h1) != 0, checking RAW and WAW.
REQ-015 SHALL drive insn_ready_o = !flush_req & !flush_ack & !hazard & (outstanding != 255) & (!issue_valid_o | issue_ready_i).
REQ-016 SHALL define accept = insn_valid_i & insn_ready_o.
REQ-017 On accept, SHALL load the output stage next cycle with issue_token_o = current token counter, issue_rd_mask_o = insn_rd_mask, and issue_valid_o = 1.
REQ-018 On issue_ready_i without accept, SHALL clear issue_valid_o.
REQ-019 While !issue_ready_i, SHALL hold the output stage stable.
REQ-020 SHALL update the token counter (8 bit) by +1 per accept, wrapping 255 -> 0, matching the commit stage's in-order increment.
REQ-021 SHALL update pending next = (pending & ~commit_mask) | (accept ? insn_rd_mask & ~1 : 0); a same-cycle set of a bit being cleared SHALL leave it set.
REQ-022 SHALL keep an outstanding counter (0..255): +1 on accept only, -1 on commit_i only, unchanged on both; it SHALL never underflow (commit_i at 0 is ignored).
REQ-023 SHALL use a flush FSM with states:
- RUN -> FLUSH when flush_req = 1.
- FLUSH -> CLEAR when flush_req = 0.
- CLEAR -> RUN after one cycle.
REQ-024 SHALL register flush_ack <= flush_req every cycle; the FSM is CLEAR exactly when flush_ack & !flush_req.
REQ-025 In the first FLUSH cycle, SHALL drop issue_valid_o to 0, regardless of issue_ready_i.
REQ-026 In CLEAR, SHALL zero token, pending and outstanding.
REQ-027 Latency: accept -> issue_valid_o is 1 cycle; a commit_mask clear unblocks a stalled instruction 1 cycle later (no bypass).

Reset
REQ-028 On rst_core_n low, SHALL reset outputs as follows: flush_ack = 1, issue_valid_o = 0, issue_token_o = 0, issue_rd_mask_o = 0, insn_ready_o = 0; token = 0, pending = 0, outstanding = 0; FSM = FLUSH.
REQ-029 After release with flush_req low, SHALL pass one CLEAR cycle and then enter RUN.
REQ-030 Reset mid-operation SHALL discard the held instruction.

Configuration
REQ-031 With ISSUE_TOKEN_BYPASS_EN defined, the hazard check SHALL use (pending & ~commit_mask), so an instruction waiting on a register retiring this cycle is accepted in the same cycle.
REQ-032 Without ISSUE_TOKEN_BYPASS_EN, the hazard check SHALL use registered pending only (REQ-014).

Verification
REQ-033 Reset release, flush_req = 0: cycle 1 insn_ready_o = 0 (CLEAR); cycle 2, accept of rd = x5 -> issue_token_o = 0, pending = 0x20.
REQ-034 RAW stall: pending bit 5 set, insn_rs_mask = 0x20 -> insn_ready_o = 0; commit_mask = 0x20 -> ready the next cycle (bypass off) or the same cycle (bypass on).
REQ-035 x0 destination: 300 back-to-back accepts of rd = x0 with commit_i each cycle -> no stalls, and the token wraps 255 -> 0 -> 44.
REQ-036 Outstanding limit: 255 accepts with no commit -> insn_ready_o = 0; one commit_i -> exactly one further accept.
REQ-037 Flush while issue_valid_o = 1 and issue_ready_i = 0: flush_req high 3 cycles -> issue_valid_o = 0 next cycle, flush_ack follows with 1-cycle lag, then after CLEAR token = 0, pending = 0.
REQ-038 Simultaneous accept and commit_i with outstanding = 10 -> outstanding stays 10.
